// File: rtl/wb_arbiter_2m1s.sv
// wb_arbiter_2m1s: two-master / one-slave Wishbone arbiter.
// Round-robin grant, registered one cycle after CYC. The owner keeps the bus for as long as
// it holds CYC. Exactly one IDLE cycle separates two owners.
// Optional macro WB_ARB_TIMEOUT_EN adds a bus-timeout watchdog. When a strobe stalls for
// TIMEOUT_CYCLES cycles, the watchdog ends the access with ERR to the owner.
// TIMEOUT_CYCLES must lie in 2..65535.
//
// state | meaning
// IDLE  | no owner; arbitrate pending CYC requests
// OWN0  | master 0 owns the slave
// OWN1  | master 1 owns the slave

module wb_arbiter_2m1s #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 6,
  parameter int SELECT_WIDTH   = DATA_WIDTH / 8,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic [ADDR_WIDTH-1:0]   m0_adr_i,
  input  logic [DATA_WIDTH-1:0]   m0_dat_i,
  output logic [DATA_WIDTH-1:0]   m0_dat_o,
  input  logic                    m0_we_i,
  input  logic [SELECT_WIDTH-1:0] m0_sel_i,
  input  logic                    m0_stb_i,
  input  logic                    m0_cyc_i,
  output logic                    m0_ack_o,
  output logic                    m0_err_o,
  output logic                    m0_rty_o,
  input  logic [ADDR_WIDTH-1:0]   m1_adr_i,
  input  logic [DATA_WIDTH-1:0]   m1_dat_i,
  output logic [DATA_WIDTH-1:0]   m1_dat_o,
  input  logic                    m1_we_i,
  input  logic [SELECT_WIDTH-1:0] m1_sel_i,
  input  logic                    m1_stb_i,
  input  logic                    m1_cyc_i,
  output logic                    m1_ack_o,
  output logic                    m1_err_o,
  output logic                    m1_rty_o,
  output logic [ADDR_WIDTH-1:0]   s_adr_o,
  output logic [DATA_WIDTH-1:0]   s_dat_o,
  output logic                    s_we_o,
  output logic [SELECT_WIDTH-1:0] s_sel_o,
  output logic                    s_stb_o,
  output logic                    s_cyc_o,
  input  logic [DATA_WIDTH-1:0]   s_dat_i,
  input  logic                    s_ack_i,
  input  logic                    s_err_i,
  input  logic                    s_rty_i,
  output logic [1:0]              grant_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } state_t;

  state_t state_q, state_d;
  // 0 = m0 owned last, 1 = m1 owned last; used only to break ties.
  logic   last_owner_q, last_owner_d;
  logic   own0, own1;
  logic   stb_raw;
  logic   term;
  logic   timeout_hit;

  // Grant state and round-robin history register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= ST_IDLE;
      last_owner_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
    end
  end

  // Arbitration: tie goes to the master that did not own the bus last; the owner is locked by CYC.
  always_comb begin
    state_d      = state_q;
    last_owner_d = last_owner_q;
    case (state_q)
      ST_IDLE: begin
        if (m0_cyc_i && m1_cyc_i) state_d = last_owner_q ? ST_OWN0 : ST_OWN1;
        else if (m0_cyc_i)        state_d = ST_OWN0;
        else if (m1_cyc_i)        state_d = ST_OWN1;
      end
      ST_OWN0: begin
        if (!m0_cyc_i) begin
          state_d      = ST_IDLE;
          last_owner_d = 1'b0;
        end
      end
      ST_OWN1: begin
        if (!m1_cyc_i) begin
          state_d      = ST_IDLE;
          last_owner_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign own0    = (state_q == ST_OWN0);
  assign own1    = (state_q == ST_OWN1);
  assign grant_o = {own1, own0};
  assign term    = s_ack_i | s_err_i | s_rty_i;

`ifdef WB_ARB_TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] stall_cnt_q;

  // The timeout fires on the TIMEOUT_CYCLES-th consecutive stalled cycle, unless the slave terminates in that same cycle.
  assign timeout_hit = stb_raw & ~term & (stall_cnt_q == TIMEOUT_LAST);

  // Stall counter: runs only while a strobe waits unanswered on an unchanged grant.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      stall_cnt_q <= 16'd0;
    end else if (!stb_raw || term || timeout_hit || (state_d != state_q)) begin
      stall_cnt_q <= 16'd0;
    end else begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // Slave-side mux driven from the grant register; everything is zero when idle.
  always_comb begin
    s_adr_o = '0;
    s_dat_o = '0;
    s_we_o  = 1'b0;
    s_sel_o = '0;
    s_cyc_o = 1'b0;
    stb_raw = 1'b0;
    if (own0) begin
      s_adr_o = m0_adr_i;
      s_dat_o = m0_dat_i;
      s_we_o  = m0_we_i;
      s_sel_o = m0_sel_i;
      s_cyc_o = m0_cyc_i;
      stb_raw = m0_cyc_i & m0_stb_i;
    end else if (own1) begin
      s_adr_o = m1_adr_i;
      s_dat_o = m1_dat_i;
      s_we_o  = m1_we_i;
      s_sel_o = m1_sel_i;
      s_cyc_o = m1_cyc_i;
      stb_raw = m1_cyc_i & m1_stb_i;
    end
  end

  assign s_stb_o = stb_raw & ~timeout_hit;

  // Return path: only the owner that still holds CYC sees terminations; a late ACK after release is dropped.
  always_comb begin
    m0_ack_o = own0 & m0_cyc_i & s_ack_i;
    m0_err_o = own0 & m0_cyc_i & (s_err_i | timeout_hit);
    m0_rty_o = own0 & m0_cyc_i & s_rty_i;
    m1_ack_o = own1 & m1_cyc_i & s_ack_i;
    m1_err_o = own1 & m1_cyc_i & (s_err_i | timeout_hit);
    m1_rty_o = own1 & m1_cyc_i & s_rty_i;
  end

  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;

endmodule
